// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrap-bit pointers, occupancy flags, sticky errors,
// flush and registered/FWFT read. Optional hwm port via SYNC_FIFO_HWM_EN.
//
// Ports: clk, reset_n (sync, active-low), clr (sync flush),
//   wr_en/wr_data, rd_en/rd_data,
//   full/empty/almost_full/almost_empty, count[N:0],
//   overflow/underflow (sticky), hwm[N:0] (SYNC_FIFO_HWM_EN only).
module sync_fifo_param #(
  parameter int W         = 8,
  parameter int N         = 4,
  parameter int AF_THRESH = (1 << N) - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [N:0]   count,
`ifdef SYNC_FIFO_HWM_EN
  output logic [N:0]   hwm,
`endif
  output logic         overflow,
  output logic         underflow
);

  localparam int       DEPTH_I = 1 << N;
  localparam logic [N:0] DEPTH = (N+1)'(DEPTH_I);
  localparam logic [N:0] AF    = (N+1)'(AF_THRESH);
  localparam logic [N:0] AE    = (N+1)'(AE_THRESH);

  if (N < 1 || N > 12) begin : g_bad_n
    $error("sync_fifo_param: N out of range 1..12");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH_I) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH_I - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [W-1:0] mem [DEPTH_I];
  logic [N:0]   wptr, rptr;
  logic [N:0]   wptr_n, rptr_n;
  logic         wr_ok, rd_ok;
  logic         live;

  // pointers carry a wrap bit, so the difference is the true occupancy
  assign count        = wptr - rptr;
  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF);
  assign almost_empty = (count <= AE);

  assign rd_ok  = rd_en && !empty;
  // a pop frees a slot in the same edge, so a full FIFO still takes a write
  assign wr_ok  = wr_en && (!full || rd_en);
  assign wptr_n = wptr + (N+1)'(wr_ok);
  assign rptr_n = rptr + (N+1)'(rd_ok);
  assign live   = reset_n && !clr;

  always_ff @(posedge clk) begin
    if (!live) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      if (wr_en && !wr_ok) overflow  <= 1'b1;
      if (rd_en && !rd_ok) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (live && wr_ok) mem[wptr[N-1:0]] <= wr_data;
  end

  if (FWFT == 0) begin : g_reg
    logic [W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (!live)      rd_q <= '0;
      else if (rd_ok) rd_q <= mem[rptr[N-1:0]];
    end
    assign rd_data = rd_q;
  end else begin : g_fwft
    assign rd_data = empty ? '0 : mem[rptr[N-1:0]];
  end

`ifdef SYNC_FIFO_HWM_EN
  logic [N:0] cnt_n;
  assign cnt_n = wptr_n - rptr_n;
  always_ff @(posedge clk) begin
    if (!live)            hwm <= '0;
    else if (cnt_n > hwm) hwm <= cnt_n;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one registered-read and one FWFT
// instance share stimulus; expected values are hand-computed constants.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset_n, clr, wr_en, rd_en;
  logic [7:0] wr_data;
  logic [7:0] rd0, rd1;
  logic       full0, empty0, af0, ae0, ov0, un0;
  logic       full1, empty1, af1, ae1, ov1, un1;
  logic [2:0] cnt0, cnt1;
`ifdef SYNC_FIFO_HWM_EN
  logic [2:0] hwm0, hwm1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.W(8), .N(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u0 (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0),
`ifdef SYNC_FIFO_HWM_EN
    .hwm(hwm0),
`endif
    .overflow(ov0), .underflow(un0)
  );

  sync_fifo_param #(.W(8), .N(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u1 (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1),
`ifdef SYNC_FIFO_HWM_EN
    .hwm(hwm1),
`endif
    .overflow(ov1), .underflow(un1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_ae", 32'(ae0), 1);
    chk("rst_af", 32'(af0), 0);
    chk("rst_ov", 32'(ov0), 0);
    chk("rst_un", 32'(un0), 0);
    chk("rst_rd0", 32'(rd0), 0);
    chk("rst_rd1", 32'(rd1), 0);
    chk("rst_empty1", 32'(empty1), 1);
    reset_n = 1'b1;

    // fill
    cyc(1, 8'h11, 0);
    chk("w1_count", 32'(cnt0), 1);
    chk("w1_empty", 32'(empty0), 0);
    chk("w1_ae", 32'(ae0), 1);
    chk("w1_fwft_head", 32'(rd1), 32'h11);
    chk("w1_rd0_hold", 32'(rd0), 0);
    cyc(1, 8'h22, 0);
    chk("w2_ae", 32'(ae0), 0);
    chk("w2_af", 32'(af0), 0);
    cyc(1, 8'h33, 0);
    chk("w3_af", 32'(af0), 1);
    chk("w3_full", 32'(full0), 0);
    cyc(1, 8'h44, 0);
    chk("w4_full", 32'(full0), 1);
    chk("w4_count", 32'(cnt0), 4);
`ifdef SYNC_FIFO_HWM_EN
    chk("hwm_full", 32'(hwm0), 4);
`endif
    cyc(1, 8'h55, 0);
    chk("ovf_flag", 32'(ov0), 1);
    chk("ovf_count", 32'(cnt0), 4);

    // drain
    cyc(0, 8'h00, 1);
    chk("r1_data", 32'(rd0), 32'h11);
    chk("r1_count", 32'(cnt0), 3);
    chk("r1_fwft_next", 32'(rd1), 32'h22);
    cyc(0, 8'h00, 1);
    chk("r2_data", 32'(rd0), 32'h22);
    cyc(0, 8'h00, 1);
    chk("r3_data", 32'(rd0), 32'h33);
    cyc(0, 8'h00, 1);
    chk("r4_data", 32'(rd0), 32'h44);
    chk("r4_empty", 32'(empty0), 1);
    chk("r4_ov_sticky", 32'(ov0), 1);
`ifdef SYNC_FIFO_HWM_EN
    chk("hwm_drained", 32'(hwm0), 4);
`endif

    // underflow, then flush
    cyc(0, 8'h00, 1);
    chk("unf_flag", 32'(un0), 1);
    chk("unf_rd0_hold", 32'(rd0), 32'h44);
    chk("unf_count", 32'(cnt0), 0);
    chk("unf_rd1", 32'(rd1), 0);
    clr = 1'b1;
    cyc(1, 8'h99, 1);
    clr = 1'b0;
    chk("clr_un", 32'(un0), 0);
    chk("clr_ov", 32'(ov0), 0);
    chk("clr_count", 32'(cnt0), 0);
    chk("clr_rd0", 32'(rd0), 0);
`ifdef SYNC_FIFO_HWM_EN
    chk("clr_hwm", 32'(hwm0), 0);
`endif

    // full with simultaneous read and write
    cyc(1, 8'h61, 0);
    cyc(1, 8'h62, 0);
    cyc(1, 8'h63, 0);
    cyc(1, 8'h64, 0);
    cyc(1, 8'h66, 1);
    chk("rw_full_count", 32'(cnt0), 4);
    chk("rw_full_data", 32'(rd0), 32'h61);
    chk("rw_full_ov", 32'(ov0), 0);
    cyc(0, 8'h00, 1);
    chk("rw_pop1", 32'(rd0), 32'h62);
    cyc(0, 8'h00, 1);
    chk("rw_pop2", 32'(rd0), 32'h63);
    cyc(0, 8'h00, 1);
    chk("rw_pop3", 32'(rd0), 32'h64);
    cyc(0, 8'h00, 1);
    chk("rw_pop4", 32'(rd0), 32'h66);
    chk("rw_empty", 32'(empty0), 1);

    // write-one/read-one across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(8'h80 + i), 0);
      chk("wrap_cnt_w", 32'(cnt0), 1);
      chk("wrap_ae_w", 32'(ae0), 1);
      chk("wrap_empty_w", 32'(empty0), 0);
      chk("wrap_fwft", 32'(rd1), 32'(8'h80 + i));
      cyc(0, 8'h00, 1);
      chk("wrap_data", 32'(rd0), 32'(8'h80 + i));
      chk("wrap_empty_r", 32'(empty0), 1);
    end

    // simultaneous read and write while empty
    cyc(1, 8'h5A, 1);
    chk("rw_empty_cnt", 32'(cnt0), 1);
    chk("rw_empty_un", 32'(un0), 1);
    chk("rw_empty_rd0", 32'(rd0), 32'h89);
    chk("rw_empty_fwft", 32'(rd1), 32'h5A);
    cyc(0, 8'h00, 1);
    chk("rw_empty_pop", 32'(rd0), 32'h5A);
    clr = 1'b1;
    cyc(0, 8'h00, 0);
    clr = 1'b0;

    // FWFT head visibility and pop
    cyc(1, 8'hA5, 0);
    chk("fwft_empty", 32'(empty1), 0);
    chk("fwft_data", 32'(rd1), 32'hA5);
    cyc(0, 8'h00, 0);
    chk("fwft_hold", 32'(rd1), 32'hA5);
    cyc(0, 8'h00, 1);
    chk("fwft_pop_empty", 32'(empty1), 1);
    chk("fwft_pop_data", 32'(rd1), 0);

    // reset mid-stream
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h03, 0);
    chk("pre_rst_cnt", 32'(cnt0), 3);
    reset_n = 1'b0;
    cyc(1, 8'hEE, 0);
    reset_n = 1'b1;
    chk("mid_rst_cnt", 32'(cnt0), 0);
    chk("mid_rst_empty", 32'(empty0), 1);
    chk("mid_rst_ov", 32'(ov0), 0);
    chk("mid_rst_rd1", 32'(rd1), 0);
    cyc(1, 8'h07, 0);
    chk("post_rst_head", 32'(rd1), 32'h07);
    chk("post_rst_cnt", 32'(cnt0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
